// File: rtl/sitina_axil_regs.sv
`timescale 1ns/1ps
// sitina_axil_regs
//   AXI4-Lite slave register block for the SITINA sensor front end.
//   Map (byte address, addr[1:0] ignored):
//     0x00 ID        RO  ID_VALUE
//     0x04 CTRL      RW  -> ctrl_out
//     0x08 STATUS    RO  status_in, sampled at the AR handshake
//     0x0C EXPOSURE  RW  -> exposure_out
//     0x10 IRQ_STAT  W1C [7:0], set on rising edges of irq_in
//     0x14 IRQ_EN    RW  [7:0]
//     0x18 SCRATCH   RW
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     s_axi_aw*/w*/b*       AXI4-Lite write address/data/response channels
//     s_axi_ar*/r*          AXI4-Lite read address/data channels
//     ctrl_out, exposure_out  current CTRL / EXPOSURE values
//     status_in, irq_in     live status word and interrupt sources (clk domain)
//     irq_out               registered |(IRQ_STAT & IRQ_EN)
module sitina_axil_regs #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] ID_VALUE = 32'h5349_5431
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       ctrl_out,
  output logic [31:0]       exposure_out,
  input  logic [31:0]       status_in,
  input  logic [7:0]        irq_in,
  output logic              irq_out
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    SEL_ID       = 3'd0,
    SEL_CTRL     = 3'd1,
    SEL_STATUS   = 3'd2,
    SEL_EXPOSURE = 3'd3,
    SEL_IRQ_STAT = 3'd4,
    SEL_IRQ_EN   = 3'd5,
    SEL_SCRATCH  = 3'd6,
    SEL_NONE     = 3'd7
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Out-of-reset flag: keeps every ready low while rst_n is asserted and
  // raises them in the first cycle after release.
  logic             run;

  logic             aw_held;
  logic [IDX_W-1:0] aw_idx;
  logic             w_held;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;

  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic [31:0]      ctrl_q;
  logic [31:0]      exposure_q;
  logic [31:0]      scratch_q;
  logic [7:0]       irq_stat_q;
  logic [7:0]       irq_en_q;
  logic [7:0]       irq_prev;
  logic             irq_q;

  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             wr_commit;
  reg_sel_e         wr_sel;
  reg_sel_e         rd_sel;
  logic [31:0]      rd_mux;
  logic [7:0]       irq_rise;
  logic [7:0]       irq_clr;

  // Byte-offset address bits are don't-care for word registers.
  logic             unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic reg_sel_e decode(input logic [IDX_W-1:0] idx);
    reg_sel_e sel;
    case (32'(idx))
      32'd0:   sel = SEL_ID;
      32'd1:   sel = SEL_CTRL;
      32'd2:   sel = SEL_STATUS;
      32'd3:   sel = SEL_EXPOSURE;
      32'd4:   sel = SEL_IRQ_STAT;
      32'd5:   sel = SEL_IRQ_EN;
      32'd6:   sel = SEL_SCRATCH;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  assign s_axi_awready = run & ~aw_held & ~bvalid_q;
  assign s_axi_wready  = run & ~w_held & ~bvalid_q;
  assign s_axi_arready = run & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign exposure_out  = exposure_q;
  assign irq_out       = irq_q;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign wr_commit = aw_held & w_held;
  assign wr_sel    = decode(aw_idx);
  assign rd_sel    = decode(s_axi_araddr[ADDR_W-1:2]);

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_ID:       rd_mux = ID_VALUE;
      SEL_CTRL:     rd_mux = ctrl_q;
      SEL_STATUS:   rd_mux = status_in;
      SEL_EXPOSURE: rd_mux = exposure_q;
      SEL_IRQ_STAT: rd_mux = {24'd0, irq_stat_q};
      SEL_IRQ_EN:   rd_mux = {24'd0, irq_en_q};
      SEL_SCRATCH:  rd_mux = scratch_q;
      default:      rd_mux = '0;
    endcase
  end

  assign irq_rise = irq_in & ~irq_prev;
  assign irq_clr  = (wr_commit && (wr_sel == SEL_IRQ_STAT) && w_strb[0]) ? w_data[7:0] : '0;

  // Handshake / channel control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      aw_held  <= 1'b0;
      aw_idx   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      run <= 1'b1;

      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end

      // Holds can only fill while bvalid is low, so a commit never
      // coincides with a pending response.
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
        rresp_q  <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file and interrupt logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      exposure_q <= '0;
      scratch_q  <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_prev   <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (wr_sel)
          SEL_CTRL:     ctrl_q     <= apply_strb(ctrl_q, w_data, w_strb);
          SEL_EXPOSURE: exposure_q <= apply_strb(exposure_q, w_data, w_strb);
          SEL_SCRATCH:  scratch_q  <= apply_strb(scratch_q, w_data, w_strb);
          SEL_IRQ_EN:   if (w_strb[0]) irq_en_q <= w_data[7:0];
          default:      ;
        endcase
      end
      irq_prev   <= irq_in;
      // Set wins over a same-cycle W1C clear.
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_rise;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_sitina_axil_regs.sv
`timescale 1ns/1ps
// tb_sitina_axil_regs
//   Self-checking bench for sitina_axil_regs: a table of directed AXI-Lite
//   read/write vectors plus hand-written multi-cycle sequences for
//   handshake timing, back-pressure, interrupt set/clear races and reset.
module tb_sitina_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [5:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [5:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] ctrl_out;
  logic [31:0] exposure_out;
  logic [31:0] status_in;
  logic [7:0]  irq_in;
  logic        irq_out;

  int n_checks;
  int n_fail;

  sitina_axil_regs #(
    .ADDR_W   (6),
    .ID_VALUE (32'h5349_5431)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .ctrl_out      (ctrl_out),
    .exposure_out  (exposure_out),
    .status_in     (status_in),
    .irq_in        (irq_in),
    .irq_out       (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    int   n;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
      n++;
    end
    check("wr_accepted", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!s_axi_bvalid && n < 50) begin
      tick();
      n++;
    end
    check("wr_bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin
      tick();
      n++;
    end
    tick();
    s_axi_arvalid = 1'b0;
    check("rd_rvalid_after_ar", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;

    n_checks = 0;
    n_fail   = 0;

    vecs.push_back('{name:"id",          wr:1'b0, addr:6'h00, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'h5349_5431});
    vecs.push_back('{name:"ctrl",        wr:1'b0, addr:6'h04, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'h0034_0078});
    vecs.push_back('{name:"ctrl_wr_b3",  wr:1'b1, addr:6'h04, data:32'hFFFF_FFFF, strb:4'h8, resp:2'b00, rdata:32'h0});
    vecs.push_back('{name:"ctrl_rd_b3",  wr:1'b0, addr:6'h04, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'hFF34_0078});
    vecs.push_back('{name:"exp_wr_hi",   wr:1'b1, addr:6'h0C, data:32'hA5A5_1234, strb:4'hC, resp:2'b00, rdata:32'h0});
    vecs.push_back('{name:"exp_rd",      wr:1'b0, addr:6'h0C, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'hA5A5_0000});
    vecs.push_back('{name:"status_rd",   wr:1'b0, addr:6'h08, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'hCAFE_0001});
    vecs.push_back('{name:"irqen_wr",    wr:1'b1, addr:6'h14, data:32'hFFFF_FF03, strb:4'hF, resp:2'b00, rdata:32'h0});
    vecs.push_back('{name:"irqen_rd",    wr:1'b0, addr:6'h14, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'h0000_0003});
    vecs.push_back('{name:"id_wr_ro",    wr:1'b1, addr:6'h00, data:32'h1111_1111, strb:4'hF, resp:2'b00, rdata:32'h0});
    vecs.push_back('{name:"id_rd_after", wr:1'b0, addr:6'h00, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'h5349_5431});
    vecs.push_back('{name:"unmap_rd_3c", wr:1'b0, addr:6'h3C, data:32'h0,         strb:4'h0, resp:2'b10, rdata:32'h0});
    vecs.push_back('{name:"unmap_wr_3c", wr:1'b1, addr:6'h3C, data:32'hFFFF_FFFF, strb:4'hF, resp:2'b10, rdata:32'h0});
    vecs.push_back('{name:"unmap_rd_1c", wr:1'b0, addr:6'h1C, data:32'h0,         strb:4'h0, resp:2'b10, rdata:32'h0});
    vecs.push_back('{name:"scratch_1b",  wr:1'b0, addr:6'h1B, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'hDEAD_BEEF});
    vecs.push_back('{name:"exp_rd2",     wr:1'b0, addr:6'h0C, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'hA5A5_0000});
    vecs.push_back('{name:"irqen_clr",   wr:1'b1, addr:6'h14, data:32'h0,         strb:4'hF, resp:2'b00, rdata:32'h0});
    vecs.push_back('{name:"irqstat_rd",  wr:1'b0, addr:6'h10, data:32'h0,         strb:4'h0, resp:2'b00, rdata:32'h0});

    rst_n         = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    status_in     = 32'hCAFE_0001;
    irq_in        = '0;

    // Reset state
    #2;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready",  32'(s_axi_wready),  32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("rst_irq_out", 32'(irq_out),       32'd0);
    check("rst_rdata",   s_axi_rdata,        32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    check("rel_awready_pre_edge", 32'(s_axi_awready), 32'd0);
    tick();
    check("rel_awready", 32'(s_axi_awready), 32'd1);
    check("rel_wready",  32'(s_axi_wready),  32'd1);
    check("rel_arready", 32'(s_axi_arready), 32'd1);
    check("rel_ctrl",    ctrl_out,           32'd0);
    check("rel_exposure", exposure_out,      32'd0);

    // AW+W same cycle: response two edges later, then 1-cycle read latency
    s_axi_awaddr  = 6'h18;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'hDEAD_BEEF;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("same_cyc_bvalid_e1", 32'(s_axi_bvalid), 32'd0);
    tick();
    check("same_cyc_bvalid_e2", 32'(s_axi_bvalid), 32'd1);
    check("same_cyc_bresp",     32'(s_axi_bresp),  32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("same_cyc_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    s_axi_araddr  = 6'h18;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check("rd18_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("rd18_rdata",  s_axi_rdata,       32'hDEAD_BEEF);
    check("rd18_rresp",  32'(s_axi_rresp),  32'd0);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rd18_rvalid_drop", 32'(s_axi_rvalid), 32'd0);

    // W three cycles ahead of AW, partial strobes
    s_axi_wdata  = 32'h1234_5678;
    s_axi_wstrb  = 4'b0101;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("w_first_wready", 32'(s_axi_wready), 32'd0);
    repeat (2) tick();
    check("w_first_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    s_axi_awaddr  = 6'h04;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("w_first_bvalid_hs", 32'(s_axi_bvalid), 32'd0);
    tick();
    check("w_first_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("w_first_bresp",  32'(s_axi_bresp),  32'd0);
    check("w_first_ctrl",   ctrl_out,          32'h0034_0078);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
        check({vecs[i].name, "_bresp"}, 32'(rsp), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, rd, rsp);
        check({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
        check({vecs[i].name, "_rresp"}, 32'(rsp), 32'(vecs[i].resp));
      end
    end
    check("tbl_ctrl_out",     ctrl_out,     32'hFF34_0078);
    check("tbl_exposure_out", exposure_out, 32'hA5A5_0000);

    // Interrupts: enable bit 0, pulse source 0
    axi_write(6'h14, 32'h0000_0001, 4'hF, rsp);
    irq_in = 8'h01;
    repeat (2) tick();
    check("irq0_out", 32'(irq_out), 32'd1);
    irq_in = 8'h00;
    axi_read(6'h10, rd, rsp);
    check("irq0_stat", rd, 32'h0000_0001);
    axi_write(6'h10, 32'h0000_0001, 4'hF, rsp);
    check("irq0_w1c_bresp", 32'(rsp), 32'd0);
    check("irq0_out_cleared", 32'(irq_out), 32'd0);
    axi_read(6'h10, rd, rsp);
    check("irq0_stat_cleared", rd, 32'h0);

    // Masked source sets status but not the output; clear needs wstrb[0]
    irq_in = 8'h02;
    repeat (3) tick();
    irq_in = 8'h00;
    check("irq1_masked_out", 32'(irq_out), 32'd0);
    axi_read(6'h10, rd, rsp);
    check("irq1_stat", rd, 32'h0000_0002);
    axi_write(6'h10, 32'h0000_00FF, 4'b1110, rsp);
    axi_read(6'h10, rd, rsp);
    check("irq1_no_strb0_kept", rd, 32'h0000_0002);
    axi_write(6'h10, 32'h0000_0002, 4'hF, rsp);
    axi_read(6'h10, rd, rsp);
    check("irq1_cleared", rd, 32'h0);

    // W1C commit on the same edge as a new rising edge: set wins
    s_axi_bready  = 1'b1;
    s_axi_awaddr  = 6'h10;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'h0000_0001;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    irq_in = 8'h01;
    tick();
    check("race_bvalid", 32'(s_axi_bvalid), 32'd1);
    tick();
    s_axi_bready = 1'b0;
    axi_read(6'h10, rd, rsp);
    check("race_stat_kept", rd, 32'h0000_0001);
    check("race_irq_out",   32'(irq_out), 32'd1);
    irq_in = 8'h00;

    // Write response back-pressure on an unmapped write
    s_axi_awaddr  = 6'h20;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'hFFFF_FFFF;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid",  32'(s_axi_bvalid),  32'd1);
      check("bp_bresp",   32'(s_axi_bresp),   32'd2);
      check("bp_awready", 32'(s_axi_awready), 32'd0);
      check("bp_wready",  32'(s_axi_wready),  32'd0);
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("bp_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    axi_read(6'h18, rd, rsp);
    check("bp_scratch_kept", rd, 32'hDEAD_BEEF);

    // Read back-pressure while status_in keeps moving
    status_in     = 32'h1111_2222;
    s_axi_araddr  = 6'h08;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      status_in = status_in + 32'h0101_0101;
      check("rbp_rvalid",  32'(s_axi_rvalid),  32'd1);
      check("rbp_rdata",   s_axi_rdata,        32'h1111_2222);
      check("rbp_arready", 32'(s_axi_arready), 32'd0);
      tick();
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rbp_rvalid_drop", 32'(s_axi_rvalid), 32'd0);

    // Read and commit to SCRATCH on the same edge return the old value
    s_axi_bready  = 1'b1;
    s_axi_awaddr  = 6'h18;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'h0000_0001;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_araddr  = 6'h18;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check("rw_same_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("rw_same_rdata",  s_axi_rdata,       32'hDEAD_BEEF);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    axi_read(6'h18, rd, rsp);
    check("rw_same_new", rd, 32'h0000_0001);

    // Reset with AW held and W outstanding
    s_axi_awaddr  = 6'h18;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("mid_awready_held", 32'(s_axi_awready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_awready", 32'(s_axi_awready), 32'd0);
    check("mid_rst_wready",  32'(s_axi_wready),  32'd0);
    check("mid_rst_arready", 32'(s_axi_arready), 32'd0);
    check("mid_rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("mid_rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("mid_rst_irq_out", 32'(irq_out),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_awready", 32'(s_axi_awready), 32'd1);
    check("mid_rel_arready", 32'(s_axi_arready), 32'd1);
    check("mid_rel_ctrl",    ctrl_out,           32'd0);
    check("mid_rel_exposure", exposure_out,      32'd0);
    s_axi_wdata  = 32'hFFFF_FFFF;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    repeat (3) tick();
    check("mid_no_commit_bvalid", 32'(s_axi_bvalid), 32'd0);
    axi_read(6'h18, rd, rsp);
    check("mid_scratch_zero", rd, 32'h0);
    axi_read(6'h14, rd, rsp);
    check("mid_irqen_zero", rd, 32'h0);
    axi_read(6'h10, rd, rsp);
    check("mid_irqstat_zero", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sitina_axil_regs.md
SITINA_AXIL_REGS -- requirements
Module: sitina_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, byte-address width of the AXI4-Lite port.
REQ-002 SHALL have parameter ID_VALUE, default 32'h5349_5431, constant returned by the ID register.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports s_axi_awaddr in ADDR_W, s_axi_awvalid in 1, s_axi_awready out 1: write address channel.
REQ-006 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
REQ-007 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response channel.
REQ-008 SHALL have ports s_axi_araddr in ADDR_W, s_axi_arvalid in 1, s_axi_arready out 1: read address channel.
REQ-009 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data channel.
REQ-010 SHALL have ports ctrl_out out 32, exposure_out out 32: current CTRL and EXPOSURE register values.
REQ-011 SHALL have ports status_in in 32, a live status word, and irq_in in 8, synchronous to clk.
REQ-012 SHALL have port irq_out  out  1, level interrupt to the PS.

Function
REQ-013 SHALL decode addr[ADDR_W-1:2], ignore addr[1:0]: 0x00 ID RO; 0x04 CTRL RW; 0x08 STATUS RO (status_in); 0x0C EXPOSURE RW; 0x10 IRQ_STAT W1C [7:0]; 0x14 IRQ_EN RW [7:0]; 0x18 SCRATCH RW.
REQ-014 SHALL read unused bits as 0 and apply wstrb per byte to all RW registers.
REQ-015 SHALL drive awready=1 only while no address is held and bvalid=0, and wready=1 only while no data is held and bvalid=0; AW and W may arrive in either order or together.
REQ-016 SHALL, once address and data are both held, commit the write on the next clock edge, set bvalid=1 on that same edge, and clear both holds.
REQ-017 SHALL hold bvalid, bresp stable until bready=1, then drop bvalid on the next edge.
REQ-018 SHALL return bresp=OKAY (2'b00) for mapped addresses, including writes to RO registers (ignored), and SLVERR (2'b10) for unmapped addresses, with no state change.
REQ-019 SHALL drive arready=1 only while rvalid=0; on an AR handshake, register rdata/rresp and set rvalid=1 on the next edge (1-cycle latency).
REQ-020 SHALL hold rvalid, rdata, rresp stable until rready=1; unmapped reads return rdata=0, rresp=SLVERR.
REQ-021 SHALL sample STATUS at the AR handshake edge; reads SHALL have no side effects.
REQ-022 SHALL set IRQ_STAT[i] on a 0->1 transition of irq_in[i] (one registered delay stage for edge detect).
REQ-023 SHALL clear IRQ_STAT[i] when a committed IRQ_STAT write has wdata[i]=1 with wstrb[0]=1; a set and a clear in the same cycle SHALL leave the bit set.
REQ-024 SHALL drive irq_out as a register of |(IRQ_STAT & IRQ_EN), updating one cycle after either changes.
REQ-025 SHALL process read and write channels independently; a simultaneous read and write to the same register SHALL return the pre-write value.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force awready, wready, bvalid, arready, rvalid, irq_out to 0, bresp, rresp to 0, rdata to 0, and all held address/data to cleared.
REQ-027 SHALL reset CTRL, EXPOSURE, IRQ_STAT, IRQ_EN, SCRATCH and the irq_in edge-detect register to 0; ready outputs SHALL assert in the first cycle after rst_n deasserts.
REQ-028 SHALL abandon any partial or pending transaction on reset, with no register update.

Verification
REQ-029 SHALL verify: AW+W same cycle to 0x18, data 32'hDEADBEEF, wstrb 4'hF -> bvalid two edges later, bresp=00; read 0x18 -> rdata 32'hDEADBEEF, rvalid one edge after AR handshake.
REQ-030 SHALL verify: W 3 cycles before AW to 0x04, data 32'h1234_5678, wstrb 4'b0101 -> ctrl_out=32'h0034_0078, bresp=00.
REQ-031 SHALL verify: read 0x00 -> 32'h5349_5431; read 0x3C -> rdata=0, rresp=10; write 0x3C -> bresp=10, no register changed.
REQ-032 SHALL verify: IRQ_EN=8'h01, irq_in[0] pulses 0->1 -> IRQ_STAT=8'h01, irq_out=1; write 0x10 data 1 in the same cycle as a new rising edge -> bit stays 1.
REQ-033 SHALL verify: bready held 0 for 5 cycles -> bvalid, bresp stable, awready=wready=0 throughout; rready held 0 -> rdata stable despite status_in changes.
REQ-034 SHALL verify: rst_n asserted with AW held, W not yet received -> all valid/ready outputs 0 immediately, registers 0 after release, no write committed.
